// File: rtl/tpu_operand_feeder.sv
// Operand feeder for the 128-lane float8 MAC: streams bytes into two operand
// vectors, holds them while the adder tree settles, then hands off the result.
module tpu_operand_feeder #(
    parameter int N_ELEM        = 128,
    parameter int ELEM_W        = 8,
    parameter int RES_W         = 15,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     hold_b,
    output logic [N_ELEM*ELEM_W-1:0] vec_a,
    output logic [N_ELEM*ELEM_W-1:0] vec_b,
    input  logic [RES_W-1:0]         mac_result,
    input  logic                     mac_overflow,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic                     res_overflow,
    output logic                     busy
);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_cnt;
    logic [N_ELEM*ELEM_W-1:0]   r_vec_a;
    logic [N_ELEM*ELEM_W-1:0]   r_vec_b;
    logic                       r_b_loaded;
    logic                       r_hold;
    logic                       r_res_valid;
    logic [RES_W-1:0]           r_res_data;
    logic                       r_res_ovf;

    logic w_xfer;
    logic w_last;
    logic w_hold;
    logic w_settled;

    assign in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign busy      = !((r_state == S_LOAD_A) && (r_idx == '0));
    assign w_xfer    = in_valid && in_ready;
    assign w_last    = (r_idx == IDX_W'(N_ELEM - 1));
    // A one-lane vector latches and decides on the same byte
    assign w_hold    = (r_idx == '0) ? hold_b : r_hold;
    assign w_settled = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

    assign vec_a        = r_vec_a;
    assign vec_b        = r_vec_b;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_overflow = r_res_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD_A;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_vec_a     <= '0;
            r_vec_b     <= '0;
            r_b_loaded  <= 1'b0;
            r_hold      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD_A: begin
                    if (w_xfer) begin
                        r_vec_a[r_idx*ELEM_W +: ELEM_W] <= in_data;
                        if (r_idx == '0) r_hold <= hold_b;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= (w_hold && r_b_loaded) ? S_SETTLE : S_LOAD_B;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_xfer) begin
                        r_vec_b[r_idx*ELEM_W +: ELEM_W] <= in_data;
                        if (w_last) begin
                            r_idx      <= '0;
                            r_b_loaded <= 1'b1;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (w_settled) begin
                        r_cnt       <= '0;
                        r_res_data  <= mac_result;
                        r_res_ovf   <= mac_overflow;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_LOAD_A;
                    end
                end
                default: r_state <= S_LOAD_A;
            endcase
        end
    end
endmodule
